// File: rtl/audioport_pkg.sv
// Shared constants and types for the I2S serial output stage.
// Frame geometry: 256 mclk per frame, sck = mclk/4, 64 slots per frame.
package audioport_pkg;

    localparam int I2S_FRAME_MCLKS    = 256;
    localparam int I2S_SCK_DIV        = 4;
    localparam int I2S_SLOTS          = 64;
    localparam int I2S_CNT_W          = 8;

    // Standard I2S: MSB lags the word-select edge by one slot.
    localparam int I2S_LEFT_MSB_SLOT  = 1;
    localparam int I2S_RIGHT_MSB_SLOT = 33;

    typedef enum logic [1:0] {
        STOP     = 2'b00,
        PLAY     = 2'b01,
        STOPPING = 2'b10
    } i2s_state_t;

endpackage

// File: rtl/i2s_fifo.sv
// Small synchronous FIFO holding stereo sample pairs for the I2S stage.
// Push while full without a simultaneous pop is dropped; push and pop in the
// same cycle while full both succeed. Flush empties the FIFO in one cycle.
module i2s_fifo #(
    parameter int FIFO_DEPTH = 2,
    parameter int WIDTH      = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    localparam int         AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    logic [WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify push/pop against the current fill level.
    always_comb begin
        do_pop_s  = pop && (count_r != '0);
        do_push_s = push && ((count_r != DEPTH_C) || do_pop_s);
    end

    // Storage, pointers and fill count; pointers wrap modulo the power-of-2 depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign full      = (count_r == DEPTH_C);
    assign empty     = (count_r == '0);
    assign head_data = mem_r[rd_ptr_r];

endmodule

// File: rtl/i2s_unit.sv
// I2S serial audio output stage (mclk domain).
// Buffers stereo pairs in i2s_fifo, loads one pair per 256-mclk frame into a
// 48-bit shift register and serialises it as standard I2S (sck, ws, sdo).
// Optional: define I2S_UNDERFLOW_DETECT_EN to add the sticky underflow_out flag.
module i2s_unit
    import audioport_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int DATA_W     = 24
) (
    input  logic              mclk,
    input  logic              mrst,
    input  logic              play_in,
    input  logic              tick_in,
    input  logic [DATA_W-1:0] audio0_in,
    input  logic [DATA_W-1:0] audio1_in,
    output logic              req_out,
    output logic              sck_out,
    output logic              ws_out,
    output logic              sdo_out
`ifdef I2S_UNDERFLOW_DETECT_EN
    ,
    output logic              underflow_out
`endif
);

    localparam int             PAIR_W   = 2 * DATA_W;
    localparam logic [7:0]     CNT_LAST = 8'(I2S_FRAME_MCLKS - 1);
    localparam logic [5:0]     L_FIRST  = 6'(I2S_LEFT_MSB_SLOT);
    localparam logic [5:0]     L_LAST   = 6'(I2S_LEFT_MSB_SLOT + DATA_W - 1);
    localparam logic [5:0]     R_FIRST  = 6'(I2S_RIGHT_MSB_SLOT);
    localparam logic [5:0]     R_LAST   = 6'(I2S_RIGHT_MSB_SLOT + DATA_W - 1);

    i2s_state_t        state_r;
    i2s_state_t        state_next_s;
    logic [7:0]        cnt_r;
    logic [7:0]        cnt_next_s;
    logic [5:0]        slot_next_s;
    logic              data_slot_s;
    logic              load_s;
    logic              flush_s;
    logic              push_s;
    logic [PAIR_W-1:0] shift_r;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [PAIR_W-1:0] fifo_head_s;
    logic              req_out_r;
    logic              sck_out_r;
    logic              ws_out_r;
    logic              sdo_out_r;

    i2s_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (PAIR_W)
    ) u_fifo (
        .clk       (mclk),
        .rst       (mrst),
        .push      (push_s),
        .pop       (load_s),
        .flush     (flush_s),
        .push_data ({audio0_in, audio1_in}),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .head_data (fifo_head_s)
    );

    // FSM state register.
    always_ff @(posedge mclk or posedge mrst) begin
        if (mrst) begin
            state_r <= STOP;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state: a running frame always completes before stopping.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            STOP: begin
                if (play_in) state_next_s = PLAY;
                else         state_next_s = STOP;
            end
            PLAY: begin
                if (!play_in && (cnt_r == CNT_LAST)) state_next_s = STOP;
                else if (!play_in)                   state_next_s = STOPPING;
                else                                 state_next_s = PLAY;
            end
            STOPPING: begin
                if (play_in)                 state_next_s = PLAY;
                else if (cnt_r == CNT_LAST)  state_next_s = STOP;
                else                         state_next_s = STOPPING;
            end
            default: state_next_s = STOP;
        endcase
    end

    // FSM-derived controls: frame load, flush, push qualification, next counter.
    always_comb begin
        load_s  = ((state_r == STOP) && (state_next_s == PLAY)) ||
                  ((state_r != STOP) && (state_next_s != STOP) && (cnt_r == CNT_LAST));
        flush_s = (state_r != STOP) && (state_next_s == STOP);
        push_s  = tick_in && (state_r != STOP) && (!fifo_full_s || load_s);
        if ((state_r == STOP) || (state_next_s == STOP)) begin
            cnt_next_s = 8'd0;
        end else begin
            cnt_next_s = cnt_r + 8'd1;
        end
        slot_next_s = cnt_next_s[7:2];
        data_slot_s = ((slot_next_s >= L_FIRST) && (slot_next_s <= L_LAST)) ||
                      ((slot_next_s >= R_FIRST) && (slot_next_s <= R_LAST));
    end

    // Frame counter, shift register and registered I2S outputs.
    // Outputs are computed from the next counter value so they line up with cnt_r.
    always_ff @(posedge mclk or posedge mrst) begin
        if (mrst) begin
            cnt_r     <= 8'd0;
            shift_r   <= '0;
            req_out_r <= 1'b0;
            sck_out_r <= 1'b0;
            ws_out_r  <= 1'b0;
            sdo_out_r <= 1'b0;
        end else begin
            cnt_r <= cnt_next_s;
            if (load_s) begin
                shift_r <= fifo_empty_s ? '0 : fifo_head_s;
            end else if (flush_s) begin
                shift_r <= '0;
            end else if ((cnt_next_s[1:0] == 2'b00) && data_slot_s) begin
                shift_r <= {shift_r[PAIR_W-2:0], 1'b0};
            end else begin
                shift_r <= shift_r;
            end
            req_out_r <= load_s;
            sck_out_r <= cnt_next_s[1];
            ws_out_r  <= cnt_next_s[7];
            if (cnt_next_s[1:0] == 2'b00) begin
                sdo_out_r <= data_slot_s ? shift_r[PAIR_W-1] : 1'b0;
            end else begin
                sdo_out_r <= sdo_out_r;
            end
        end
    end

    assign req_out = req_out_r;
    assign sck_out = sck_out_r;
    assign ws_out  = ws_out_r;
    assign sdo_out = sdo_out_r;

`ifdef I2S_UNDERFLOW_DETECT_EN
    logic underflow_r;

    // Sticky underflow: empty FIFO at a steady-state load; cleared on entering STOP.
    always_ff @(posedge mclk or posedge mrst) begin
        if (mrst) begin
            underflow_r <= 1'b0;
        end else if (flush_s) begin
            underflow_r <= 1'b0;
        end else if (load_s && fifo_empty_s && (state_r != STOP)) begin
            underflow_r <= 1'b1;
        end else begin
            underflow_r <= underflow_r;
        end
    end

    assign underflow_out = underflow_r;
`endif

endmodule

// File: tb/tb_i2s_unit.sv
// Self-checking bench for i2s_unit: directed sequence with random sample data,
// checked every cycle against a frame-level reference model (queue FIFO,
// frame position counter, I2S bit mapping computed from slot arithmetic).
module tb_i2s_unit;

    localparam int DEPTH = 2;

    logic        mclk = 1'b0;
    logic        mrst = 1'b0;
    logic        play_in = 1'b0;
    logic        tick_in = 1'b0;
    logic [23:0] audio0_in = 24'd0;
    logic [23:0] audio1_in = 24'd0;
    logic        req_out;
    logic        sck_out;
    logic        ws_out;
    logic        sdo_out;
`ifdef I2S_UNDERFLOW_DETECT_EN
    logic        underflow_out;
`endif

    int checks = 0;
    int errors = 0;

    // reference model state
    bit          m_running = 1'b0;
    int          m_pos = 0;
    logic [47:0] m_cur = 48'd0;
    logic [47:0] q[$];
    bit          m_first = 1'b0;
    bit          m_uf = 1'b0;

    i2s_unit #(
        .FIFO_DEPTH (DEPTH),
        .DATA_W     (24)
    ) dut (
        .mclk      (mclk),
        .mrst      (mrst),
        .play_in   (play_in),
        .tick_in   (tick_in),
        .audio0_in (audio0_in),
        .audio1_in (audio1_in),
        .req_out   (req_out),
        .sck_out   (sck_out),
        .ws_out    (ws_out),
`ifdef I2S_UNDERFLOW_DETECT_EN
        .sdo_out   (sdo_out),
        .underflow_out (underflow_out)
`else
        .sdo_out   (sdo_out)
`endif
    );

    always #5 mclk = ~mclk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s pos=%0d running=%0d observed=%b expected=%b", tag, m_pos, m_running, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_running = 1'b0;
        m_pos     = 0;
        m_cur     = 48'd0;
        q.delete();
        m_first   = 1'b0;
        m_uf      = 1'b0;
    endtask

    task automatic check_outputs();
        logic e_sck, e_ws, e_sdo, e_req;
        int   slot;
        if (m_running) begin
            slot  = m_pos / 4;
            e_sck = ((m_pos / 2) % 2) == 1;
            e_ws  = slot >= 32;
            e_req = m_pos == 0;
            if (slot >= 1 && slot <= 24)       e_sdo = m_cur[48 - slot];
            else if (slot >= 33 && slot <= 56) e_sdo = m_cur[56 - slot];
            else                               e_sdo = 1'b0;
        end else begin
            e_sck = 1'b0;
            e_ws  = 1'b0;
            e_sdo = 1'b0;
            e_req = 1'b0;
        end
        chk("req_out", req_out, e_req);
        chk("sck_out", sck_out, e_sck);
        chk("ws_out",  ws_out,  e_ws);
        chk("sdo_out", sdo_out, e_sdo);
`ifdef I2S_UNDERFLOW_DETECT_EN
        chk("underflow_out", underflow_out, m_uf);
`endif
    endtask

    // One mclk cycle: drive inputs, advance the model at the edge, check #1 later.
    task automatic step(input logic p, input logic t, input logic [23:0] a0, input logic [23:0] a1);
        bit was_running;
        bit start;
        bit stop;
        play_in   = p;
        tick_in   = t;
        audio0_in = a0;
        audio1_in = a1;
        @(posedge mclk);
        was_running = m_running;
        start = 1'b0;
        stop  = 1'b0;
        if (!m_running) begin
            if (p) begin
                m_running = 1'b1;
                m_pos     = 0;
                start     = 1'b1;
                m_first   = 1'b1;
            end
        end else if (m_pos == 255) begin
            if (p) begin
                m_pos   = 0;
                start   = 1'b1;
                m_first = 1'b0;
            end else begin
                m_running = 1'b0;
                m_pos     = 0;
                stop      = 1'b1;
            end
        end else begin
            m_pos++;
        end
        if (start) begin
            if (q.size() > 0) begin
                m_cur = q.pop_front();
            end else begin
                m_cur = 48'd0;
                if (!m_first) m_uf = 1'b1;
            end
        end
        if (was_running && t && q.size() < DEPTH) q.push_back({a0, a1});
        if (stop) begin
            q.delete();
            m_uf  = 1'b0;
            m_cur = 48'd0;
        end
        #1;
        check_outputs();
    endtask

    // Run n cycles; a tick is issued whenever the model position matches t0..t3.
    task automatic run(input int n, input logic p, input int t0, input int t1, input int t2,
                       input int t3, input bit rnd, input logic [23:0] a0, input logic [23:0] a1);
        for (int i = 0; i < n; i++) begin
            logic        tk;
            logic [23:0] d0;
            logic [23:0] d1;
            tk = (m_pos == t0) || (m_pos == t1) || (m_pos == t2) || (m_pos == t3);
            d0 = rnd ? 24'($urandom) : a0;
            d1 = rnd ? 24'($urandom) : a1;
            step(p, tk, d0, d1);
        end
    endtask

    initial begin
        #1 mrst = 1'b1;
        #11;
        model_reset();
        check_outputs();
        @(negedge mclk);
        mrst = 1'b0;

        // STOP: ticks ignored, outputs stay low
        run(5, 1'b0, 0, -1, -1, -1, 1'b1, 24'd0, 24'd0);

        // start with empty FIFO: silent first frame, known pattern pushed at pos 10
        step(1'b1, 1'b0, 24'd0, 24'd0);
        run(256, 1'b1, 10, -1, -1, -1, 1'b0, 24'h800001, 24'h7FFFFE);
        // pattern frame, random pair pushed for the next one
        run(256, 1'b1, 100, -1, -1, -1, 1'b1, 24'd0, 24'd0);
        // fill to full, third dropped, tick coinciding with the pop at frame end accepted
        run(256, 1'b1, 20, 30, 40, 255, 1'b1, 24'd0, 24'd0);
        // drain three frames, then one underflowing frame with a refill
        run(768, 1'b1, -1, -1, -1, -1, 1'b1, 24'd0, 24'd0);
        run(256, 1'b1, 50, -1, -1, -1, 1'b1, 24'd0, 24'd0);

        // random tick patterns
        for (int f = 0; f < 4; f++) begin
            int tp[4];
            for (int k = 0; k < 4; k++) begin
                tp[k] = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 255));
            end
            run(256, 1'b1, tp[0], tp[1], tp[2], tp[3], 1'b1, 24'd0, 24'd0);
        end

        // play falls at slot 10: frame completes, then idle in STOP
        run(40, 1'b1, -1, -1, -1, -1, 1'b1, 24'd0, 24'd0);
        run(216 + 30, 1'b0, 100, -1, -1, -1, 1'b1, 24'd0, 24'd0);

        // restart; play dropped at slot 10 and restored at slot 40 keeps FIFO contents
        step(1'b1, 1'b0, 24'd0, 24'd0);
        run(256, 1'b1, 10, 20, -1, -1, 1'b1, 24'd0, 24'd0);
        run(40, 1'b1, -1, -1, -1, -1, 1'b1, 24'd0, 24'd0);
        run(120, 1'b0, -1, -1, -1, -1, 1'b1, 24'd0, 24'd0);
        run(96, 1'b1, -1, -1, -1, -1, 1'b1, 24'd0, 24'd0);
        run(256, 1'b1, 30, -1, -1, -1, 1'b1, 24'd0, 24'd0);

        // asynchronous reset mid-frame at pos 100
        run(100, 1'b1, -1, -1, -1, -1, 1'b1, 24'd0, 24'd0);
        #3 mrst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge mclk);
        #1;
        check_outputs();
        @(negedge mclk);
        mrst = 1'b0;
        run(10, 1'b0, -1, -1, -1, -1, 1'b1, 24'd0, 24'd0);
        // after reset: STOP, FIFO empty, so the first frame is silent
        step(1'b1, 1'b0, 24'd0, 24'd0);
        run(300, 1'b1, 60, -1, -1, -1, 1'b1, 24'd0, 24'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_unit.md
Name: i2s_unit

Overview:
- Serial audio output stage in the mclk domain, directly downstream of the clock-domain-crossing unit.
- Consumes the synchronised `play`, `tick` and 24-bit stereo samples it delivers.
- Buffers the samples in a small FIFO and serialises them as a standard I2S stream (`sck`, `ws`, `sdo`).
- Returns a one-cycle `req_out` pulse per frame to request the next sample pair.

Parameters:
- FIFO_DEPTH, 2, number of stereo sample pairs buffered (power of 2, ≥2)
- DATA_W, 24, bits per channel sample

Ports:
- mclk  input  1  audio master clock; all logic on rising edge
- mrst  input  1  asynchronous, active-high reset
- play_in  input  1  playback enable, already synchronised to mclk
- tick_in  input  1  one-cycle pulse: audio0_in/audio1_in valid
- audio0_in  input  DATA_W  left-channel sample, two's complement
- audio1_in  input  DATA_W  right-channel sample
- req_out  output  1  one-cycle pulse requesting the next sample pair
- sck_out  output  1  I2S bit clock = mclk/4
- ws_out  output  1  I2S word select, 0 = left, 1 = right
- sdo_out  output  1  I2S serial data, MSB first

Behaviour:
- Reset (mrst = 1, asynchronous):
  - req_out, sck_out, ws_out, sdo_out = 0.
  - FIFO empty, shift register 0, frame counter `cnt` = 0, state STOP.
- Frame timing:
  - 8-bit counter `cnt`, 0..255, free-running in PLAY/STOPPING, held at 0 in STOP.
  - sck_out = cnt[1], registered; low for cnt[1:0] ∈ {0,1}, high for {2,3}.
  - Slot index = cnt[7:2], 0..63; one slot per sck period; 256 mclk per frame.
- Serial format (standard I2S, 1-slot delay):
  - ws_out = 0 for slots 0..31, 1 for slots 32..63.
  - sdo_out carries audio0[23..0] in slots 1..24 and audio1[23..0] in slots 33..56; 0 in all other slots.
  - sdo_out and ws_out change only on cycles where cnt[1:0] == 0, i.e. the sck falling edge.
- Frame load:
  - On the cycle cnt wraps 255 → 0, and on the first cycle of PLAY, the FIFO head is popped into the 48-bit shift register.
  - If the FIFO is empty, zeros are loaded (underflow) and the frame plays silence.
  - req_out = 1 for exactly one mclk cycle, coinciding with cnt == 0 of every frame started in PLAY; never in STOPPING or STOP.
- FIFO:
  - tick_in pushes {audio0_in, audio1_in}.
  - Push while full and no simultaneous pop: new data dropped, contents unchanged.
  - Simultaneous push and pop while full: both succeed.
  - Pointers wrap modulo FIFO_DEPTH.
- State machine (i2s_state_t):
  - STOP → PLAY when play_in = 1. cnt starts at 0, first load pops the FIFO (empty after a stop, so the first frame is silent) and issues req_out.
  - PLAY → STOPPING when play_in = 0.
  - STOPPING → PLAY if play_in returns to 1 before frame end; no flush, no gap.
  - STOPPING → STOP at cnt == 255 with play_in = 0: the current frame always completes. On entering STOP the FIFO is flushed and all outputs are 0.
  - tick_in in STOP is ignored.
- Latency:
  - A sample pushed by tick_in appears on sdo starting at the next frame load, i.e. at most 256 mclk after the request that fetched it.
- Reset mid-frame aborts immediately: all outputs 0, no frame completion.

Optional Feature:
- Macro I2S_UNDERFLOW_DETECT_EN.
- When defined:
  - Adds output port underflow_out (1 bit), reset 0.
  - Sticky; set on the cycle a frame load finds the FIFO empty while in PLAY, except the first load after STOP → PLAY.
  - Cleared on entry to STOP.
- When undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- audioport_pkg holds:
  - I2S_FRAME_MCLKS = 256, I2S_SCK_DIV = 4, I2S_SLOTS = 64.
  - Left/right MSB slot constants, 1 and 33.
  - Enum i2s_state_t {STOP, PLAY, STOPPING}.
- Sub-module i2s_fifo: synchronous FIFO, parameters FIFO_DEPTH and width 2*DATA_W; push, pop, flush, full, empty, head data. The frame counter, FSM and shift register stay in i2s_unit.

Test Plan:
- Reset mid-frame (cnt = 100, PLAY) → all outputs 0 within the same cycle, FIFO empty, state STOP after release.
- play_in rises, FIFO empty → first frame sdo all 0, req_out pulse at cnt = 0; tick_in with audio0 = 24'h800001, audio1 = 24'h7FFFFE → next frame sdo slot 1 = 1, slot 24 = 1, slot 33 = 0, slots 34..55 = 1, slot 56 = 0; ws_out toggles at slots 0 and 32.
- sck check: sck_out period 4 mclk, 50% duty; sdo/ws transitions occur only while sck_out falls.
- FIFO full (depth 2) plus third tick_in without pop → third pair dropped; frames play pairs 1 and 2 in order. Tick coinciding with a pop while full → accepted.
- play_in falls at slot 10 → frame completes through slot 63, no further req_out, outputs 0 afterward. A second run with play_in reasserted at slot 40 → playback continues seamlessly, FIFO contents preserved.
- I2S_UNDERFLOW_DETECT_EN defined: withhold tick_in for one frame in steady PLAY → underflow_out rises at that load and stays 1 until STOP.
